// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM states, the squash NOP word and the sequential PC step.
// Pure declarations, no logic; backpressure n/a.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC select, priority jump > branch > stall hold > PC+4; purely combinational (0 cycles).
// Backpressure: stall holds the current PC unless a redirect wins.
module next_pc_logic
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] if_id_pc4_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [15:0] branch_offset_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  output logic [31:0] next_pc_o,
  output logic        redirect_o
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // Word offset, sign-extended and scaled to bytes; the add wraps at 32 bits.
  assign branch_target = if_id_pc4_i + {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};
  assign jump_target   = {if_id_pc4_i[31:28], jump_index_i, 2'b00};

  always_comb begin
    redirect_o = jump_i | branch_taken_i;
    next_pc_o  = pc_i + PC_STEP;
    if (jump_i) begin
      next_pc_o = jump_target;
    end else if (branch_taken_i) begin
      next_pc_o = branch_target;
    end else if (stall_i) begin
      next_pc_o = pc_i;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, IF/ID latch and BOOT/RUN/FAULT control; instruction reaches IF/ID one cycle after PC.
// Backpressure: stall freezes PC and IF/ID; redirects override stall; FAULT freezes everything until reset.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 37
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] Instruction_Code,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_valid,
  output logic        fetch_fault
);

  localparam logic [32:0] LAST_BYTE = 33'(IMEM_BYTES - 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic         fault_q, fault_d;

  logic [31:0]  npc;
  logic         redirect;
  logic         fetch_bad;

  next_pc_logic u_next_pc (
    .pc_i            (pc_q),
    .if_id_pc4_i     (pc4_q),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_offset_i (branch_offset),
    .jump_i          (jump),
    .jump_index_i    (jump_index),
    .next_pc_o       (npc),
    .redirect_o      (redirect)
  );

  // 33-bit compare so a PC near the top of the address space cannot wrap into range.
  assign fetch_bad = (pc_q[1:0] != 2'b00) || (({1'b0, pc_q} + 33'd3) > LAST_BYTE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (fetch_bad) begin
          instr_d = NOP;
          valid_d = 1'b0;
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else if (redirect) begin
          pc_d    = npc;
          instr_d = NOP;
          valid_d = 1'b0;
        end else if (stall) begin
          if (flush) begin
            instr_d = NOP;
            valid_d = 1'b0;
          end
        end else begin
          pc_d = npc;
          if (flush) begin
            instr_d = NOP;
            valid_d = 1'b0;
          end else begin
            instr_d = Instruction_Code;
            pc4_d   = pc_q + PC_STEP;
            valid_d = 1'b1;
          end
        end
      end
      ST_FAULT: ;
      default: state_d = ST_BOOT;
    endcase
  end

  assign PC                = pc_q;
  assign IF_ID_Instruction = instr_q;
  assign IF_ID_PC4         = pc4_q;
  assign IF_ID_valid       = valid_q;
  assign fetch_fault       = fault_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter IMEM_BYTES, default 37: byte depth of the instruction memory; bounds limit for fetch.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard hold from decode: freeze PC and IF/ID.
REQ-006 flush  input  1  squash the IF/ID entry without redirecting.
REQ-007 branch_taken  input  1  redirect to the branch target this cycle.
REQ-008 branch_offset  input  16  signed word offset, relative to IF_ID_PC4.
REQ-009 jump  input  1  redirect to the jump target this cycle.
REQ-010 jump_index  input  26  J-type target index.
REQ-011 Instruction_Code  input  32  big-endian word returned combinationally by instruction memory for PC.
REQ-012 PC  output  32  current fetch address driven to instruction memory.
REQ-013 IF_ID_Instruction  output  32  latched instruction for decode.
REQ-014 IF_ID_PC4  output  32  latched PC+4 of that instruction.
REQ-015 IF_ID_valid  output  1  IF/ID entry holds a real instruction.
REQ-016 fetch_fault  output  1  sticky misaligned or out-of-range fetch indicator.

Function
REQ-017 The FSM SHALL have three states: BOOT, RUN, FAULT.
REQ-018 BOOT is entered on reset and lasts exactly one cycle, with PC held at RESET_PC and IF/ID not loaded; it then moves to RUN unconditionally.
REQ-019 In RUN, the next PC SHALL be selected with priority jump > branch_taken > stall (hold) > PC+4.
REQ-020 Branch target SHALL be IF_ID_PC4 + (sign-extended branch_offset << 2), with 32-bit wrap-around.
REQ-021 Jump target SHALL be {IF_ID_PC4[31:28], jump_index, 2'b00}.
REQ-022 When jump and branch_taken are both asserted, jump SHALL win.
REQ-023 A redirect SHALL override stall.
REQ-024 On a redirect, the IF/ID entry SHALL load IF_ID_Instruction=32'h0, IF_ID_valid=0 (wrong-path squash); IF_ID_PC4 is don't-care.
REQ-025 With stall and no redirect, PC, IF_ID_Instruction, IF_ID_PC4 and IF_ID_valid SHALL hold.
REQ-026 With flush and no redirect, IF_ID_valid SHALL become 0 and IF_ID_Instruction 32'h0. PC advances unless stall is also asserted.
REQ-027 Otherwise in RUN, IF/ID SHALL load Instruction_Code, PC+4 and valid=1 on the next edge; decode sees the instruction one cycle after PC is presented.
REQ-028 A fetch SHALL be faulting when PC[1:0]!=0 or PC+3 > IMEM_BYTES-1, compared with 33-bit arithmetic so that no wrap occurs.
REQ-029 A faulting fetch SHALL not be latched: IF_ID_valid=0, fetch_fault=1, PC holds, and the FSM enters FAULT.
REQ-030 FAULT SHALL be terminal until reset: PC holds, IF_ID_valid stays 0, and all redirect, stall and flush inputs are ignored.

Reset
REQ-031 With reset high at a clock edge, the following SHALL apply: PC=RESET_PC, IF_ID_Instruction=0, IF_ID_PC4=0, IF_ID_valid=0, fetch_fault=0, state=BOOT.
REQ-032 Reset asserted mid-operation, including in FAULT or during stall, SHALL take priority over every other input.
REQ-033 Outputs SHALL not change asynchronously with reset.

Structure
REQ-034 FSM state encodings, the NOP constant (32'h0) and the PC step (4) SHALL live in a shared package mips_pkg.
REQ-035 Next-PC selection SHALL be a single combinational sub-module, next_pc_logic, with the PC register and IF/ID register kept in instruction_fetch.

Verification
REQ-036 Reset, then release with the default program: PC sequence 0,0(BOOT),4,8. IF_ID_Instruction=32'h8C41000A with valid=1 and IF_ID_PC4=4 one cycle after PC=0 in RUN.
REQ-037 Branch: when IF_ID_PC4=8 and branch_offset=16'hFFFE with branch_taken=1, next PC=0, and the following IF/ID entry has valid=0.
REQ-038 Jump with branch: jump=1, jump_index=26'h4 and branch_taken=1 in the same cycle give next PC=32'h10; IF_ID_Instruction=32'h3061000A two cycles later.
REQ-039 Stall: stall held 3 cycles at PC=8 keeps PC=8 and IF/ID=32'hAC610005. Adding branch_taken during the stall redirects anyway.
REQ-040 Bounds: sequential run reaches PC=36, and fetch_fault=1 on the next edge. Afterward PC stays 36 and valid=0 despite jump=1. Reset clears the fault and returns PC to 0.
REQ-041 Misalignment: RESET_PC=2 leads to fetch_fault=1 on the first RUN edge, with no valid IF/ID entry ever produced.
